// File: rtl/aes_pkg.sv
// Shared definitions for the AES stream loader: block/word geometry and the
// loader state encoding.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_WORD_W  = 32;
  localparam int AES_WORDS   = 4;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } loader_state_t;

endpackage

// File: rtl/aes_word_serializer.sv
// Holds a captured 128-bit ciphertext and hands it out as four 32-bit words,
// most significant word first, over a valid/ready handshake.
module aes_word_serializer
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [AES_BLOCK_W-1:0] block_in,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [AES_WORD_W-1:0]  out_word,
  output logic                   last_accept
);

  logic [AES_BLOCK_W-1:0] block_q;
  logic [1:0]             idx_q;
  logic                   valid_q;

  // Capture a new block on load, then step through its words as each one is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      block_q <= '0;
      idx_q   <= 2'd0;
      valid_q <= 1'b0;
    end else if (load) begin
      block_q <= block_in;
      idx_q   <= 2'd0;
      valid_q <= 1'b1;
    end else if (valid_q && out_ready) begin
      if (idx_q == 2'(AES_WORDS - 1)) begin
        idx_q   <= 2'd0;
        valid_q <= 1'b0;
      end else begin
        idx_q <= idx_q + 2'd1;
      end
    end
  end

  // Pick the current word from the held block; it only moves when the index does.
  always_comb begin
    out_word = block_q[127:96];
    case (idx_q)
      2'd0: out_word = block_q[127:96];
      2'd1: out_word = block_q[95:64];
      2'd2: out_word = block_q[63:32];
      2'd3: out_word = block_q[31:0];
      default: out_word = block_q[127:96];
    endcase
  end

  assign out_valid   = valid_q;
  assign last_accept = valid_q && out_ready && (idx_q == 2'(AES_WORDS - 1));

endmodule

// File: rtl/aes_stream_loader.sv
// Staging stage in front of the AES core: assembles key and plaintext from a
// 32-bit word stream, runs the core with a timeout, and streams the
// ciphertext back out through the word serializer.
module aes_stream_loader
  import aes_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   AES_clk,
  input  logic                   AES_rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_WORD_W-1:0]  in_word,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_WORD_W-1:0]  out_word,
  output logic                   busy,
  output logic                   timeout_err,
  output logic                   AES_en,
  output logic [AES_BLOCK_W-1:0] AES_data_in,
  output logic [AES_BLOCK_W-1:0] AES_key_in,
  input  logic [AES_BLOCK_W-1:0] AES_data_out,
  input  logic                   AES_data_out_valid
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  loader_state_t          state_q;
  loader_state_t          state_d;
  logic [2:0]             word_idx_q;
  logic [AES_BLOCK_W-1:0] key_q;
  logic [AES_BLOCK_W-1:0] data_q;
  logic [CNT_W-1:0]       tmo_cnt_q;
  logic                   timeout_err_q;
  logic                   accept;
  logic                   result_hit;
  logic                   tmo_hit;
  logic                   drain_done;

  assign accept     = in_valid && (state_q == LOAD);
  assign result_hit = (state_q == RUN) && AES_data_out_valid;
  assign tmo_hit    = (state_q == RUN) && !AES_data_out_valid &&
                      (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // State register.
  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) state_q <= LOAD;
    else            state_q <= state_d;
  end

  // Next state: eight words start a run, a result or timeout ends it, the fourth output word ends the drain.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (accept && (word_idx_q == 3'd7)) state_d = RUN;
      RUN:     if (result_hit)   state_d = DRAIN;
               else if (tmo_hit) state_d = LOAD;
      DRAIN:   if (drain_done)   state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // Word assembly: words 0-3 fill the key and 4-7 the data, MSW first; registers are only written in LOAD.
  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      word_idx_q <= 3'd0;
      key_q      <= '0;
      data_q     <= '0;
    end else if (accept) begin
      word_idx_q <= word_idx_q + 3'd1;
      case (word_idx_q)
        3'd0: key_q[127:96]  <= in_word;
        3'd1: key_q[95:64]   <= in_word;
        3'd2: key_q[63:32]   <= in_word;
        3'd3: key_q[31:0]    <= in_word;
        3'd4: data_q[127:96] <= in_word;
        3'd5: data_q[95:64]  <= in_word;
        3'd6: data_q[63:32]  <= in_word;
        3'd7: data_q[31:0]   <= in_word;
        default: ;
      endcase
    end
  end

  // Timeout counter runs only in RUN and clears on leaving it; the error flag is a registered one-cycle pulse.
  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= tmo_hit;
      if ((state_q == RUN) && !result_hit && !tmo_hit) tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
      else                                             tmo_cnt_q <= '0;
    end
  end

  aes_word_serializer u_serializer (
    .clk         (AES_clk),
    .rst_n       (AES_rst_n),
    .load        (result_hit),
    .block_in    (AES_data_out),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_word    (out_word),
    .last_accept (drain_done)
  );

  assign in_ready    = (state_q == LOAD);
  assign AES_en      = (state_q == RUN);
  assign busy        = (state_q == RUN);
  assign timeout_err = timeout_err_q;
  assign AES_key_in  = key_q;
  assign AES_data_in = data_q;

endmodule

// File: tb/tb_aes_stream_loader.sv
// Self-checking bench for aes_stream_loader with a behavioural AES-128 core
// model standing in for AES_top, plus stub modes for timeout corner cases.
module tb_aes_stream_loader;

  localparam int TIMEOUT = 8;
  localparam int LATENCY = 5;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B2B_KEY  = 128'haa2bdb40bff6a5e8caa9ba3ebc1e2acc;
  localparam logic [127:0] B2B_PT0  = 128'h000000f0000000000000000000000000;
  localparam logic [127:0] B2B_PT1  = 128'ha6f2daeb140fa720529e75d521cbc681;
  localparam logic [127:0] STUB_CT  = 128'h0123456789abcdeffedcba9876543210;

  logic         AES_clk;
  logic         AES_rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_word;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_word;
  logic         busy;
  logic         timeout_err;
  logic         AES_en;
  logic [127:0] AES_data_in;
  logic [127:0] AES_key_in;
  logic [127:0] AES_data_out;
  logic         AES_data_out_valid;

  int checks = 0;
  int errors = 0;

  int           core_mode = 0;
  int           en_cnt = 0;
  logic [127:0] core_result = '0;
  bit           out_stall = 0;

  logic [31:0]  exp_q [$];
  logic [255:0] pending_q [$];
  logic [255:0] cur_kd = '0;
  bit           prev_en = 0;
  bit           held_valid = 0;
  logic [31:0]  held_word = '0;

  logic [7:0] sbox_tab [256];

  typedef struct {
    logic [127:0] key;
    logic [127:0] data;
    bit           in_stall;
    bit           out_stall;
    logic [127:0] exp_ct;
  } vec_t;

  vec_t vecs [5];

  aes_stream_loader #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .AES_clk            (AES_clk),
    .AES_rst_n          (AES_rst_n),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_word            (in_word),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_word           (out_word),
    .busy               (busy),
    .timeout_err        (timeout_err),
    .AES_en             (AES_en),
    .AES_data_in        (AES_data_in),
    .AES_key_in         (AES_key_in),
    .AES_data_out       (AES_data_out),
    .AES_data_out_valid (AES_data_out_valid)
  );

  // Free-running clock.
  initial AES_clk = 1'b0;
  always #5 AES_clk = ~AES_clk;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] t);
    return {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rcon;
    logic [7:0]   b [16];
    logic [7:0]   n [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] s;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = sub_word(t) ^ {rcon, 24'h000000};
        rcon = xtime(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    s = pt ^ {w[0], w[1], w[2], w[3]};
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) b[i] = sbox_tab[s[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          n[rr+4*c] = b[rr+4*((c+rr)%4)];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = n[4*c]; a1 = n[4*c+1]; a2 = n[4*c+2]; a3 = n[4*c+3];
          b[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          b[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          b[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          b[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end else begin
        b = n;
      end
      for (int i = 0; i < 16; i++) s[127-8*i -: 8] = b[i];
      s = s ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    return s;
  endfunction

  // Core model: counts enabled cycles, computes the ciphertext once per run, and raises valid at the chosen latency.
  always @(posedge AES_clk) begin
    if (!AES_en) begin
      en_cnt <= 0;
    end else begin
      en_cnt <= en_cnt + 1;
      if (en_cnt == 0) core_result <= aes_encrypt(AES_key_in, AES_data_in);
    end
  end

  assign AES_data_out_valid = AES_en && (core_mode != 1) &&
                              (en_cnt == ((core_mode == 2) ? (TIMEOUT - 1) : (LATENCY - 1)));
  assign AES_data_out = (core_mode == 2) ? STUB_CT : core_result;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Output side: drive out_ready, score each accepted word, check holds, key/data stability and in_ready blocking.
  always @(negedge AES_clk) begin
    if (AES_rst_n) begin
      if (held_valid && out_valid) checkOutput("out_word_hold", 128'(out_word), 128'(held_word));
      out_ready = out_stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_word: got %h, expected no output", out_word);
        end else begin
          checkOutput("out_word", 128'(out_word), 128'(exp_q.pop_front()));
        end
      end
      held_valid = out_valid && !out_ready;
      held_word  = out_word;
      if (AES_en && !prev_en) begin
        if (pending_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_run: got AES_en=1, expected no run");
        end else begin
          cur_kd = pending_q.pop_front();
        end
      end
      if (AES_en) begin
        checkOutput("key_stable", AES_key_in, cur_kd[255:128]);
        checkOutput("data_stable", AES_data_in, cur_kd[127:0]);
      end
      if (AES_en || out_valid) checkOutput("in_ready_blocked", 128'(in_ready), 128'(0));
      prev_en = AES_en;
    end else begin
      held_valid = 0;
      prev_en    = 0;
    end
  end

  task automatic send_word(input logic [31:0] w, input bit stall);
    int guard = 0;
    while (stall && ($urandom_range(0, 1) == 1) && guard < 20) begin
      @(negedge AES_clk);
      guard++;
    end
    in_valid = 1'b1;
    in_word  = w;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge AES_clk);
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      errors++;
      $display("[TB] FAIL in_ready_wait: got in_ready=0 for 200 cycles, expected 1");
    end
    @(negedge AES_clk);
    in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [127:0] key, input logic [127:0] data,
                               input bit stall, input bit push_exp, input logic [127:0] exp_ct);
    logic [255:0] kd;
    kd = {key, data};
    pending_q.push_back(kd);
    if (push_exp) for (int k = 0; k < 4; k++) exp_q.push_back(exp_ct[127-32*k -: 32]);
    for (int i = 0; i < 8; i++) send_word(kd[255-32*i -: 32], stall);
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(negedge AES_clk);
      guard++;
    end
    if (guard >= 500) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_wait: got %0d words pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge AES_clk);
  endtask

  task automatic check_reset_state();
    checkOutput("rst_in_ready", 128'(in_ready), 128'(1));
    checkOutput("rst_out_valid", 128'(out_valid), 128'(0));
    checkOutput("rst_out_word", 128'(out_word), 128'(0));
    checkOutput("rst_busy", 128'(busy), 128'(0));
    checkOutput("rst_timeout_err", 128'(timeout_err), 128'(0));
    checkOutput("rst_aes_en", 128'(AES_en), 128'(0));
    checkOutput("rst_data_in", AES_data_in, 128'(0));
    checkOutput("rst_key_in", AES_key_in, 128'(0));
  endtask

  task automatic pulse_reset();
    #2 AES_rst_n = 1'b0;
    #1 check_reset_state();
    pending_q.delete();
    exp_q.delete();
    @(negedge AES_clk);
    AES_rst_n = 1'b1;
    @(negedge AES_clk);
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #300000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish before 300us");
    $fatal(1, "[TB] simulation time limit reached");
  end

  // Main test sequence.
  initial begin
    int en_cycles;
    int err_pulses;
    logic [7:0] inv;
    logic [7:0] x8;

    for (int x = 0; x < 256; x++) begin
      x8  = 8'(x);
      inv = 8'h00;
      if (x != 0) for (int y = 1; y < 256; y++) if (gmul(x8, 8'(y)) == 8'h01) inv = 8'(y);
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end

    vecs[0] = '{key: FIPS_KEY, data: FIPS_PT, in_stall: 0, out_stall: 0, exp_ct: FIPS_CT};
    vecs[1] = '{key: FIPS_KEY, data: FIPS_PT, in_stall: 1, out_stall: 1, exp_ct: FIPS_CT};
    vecs[2] = '{key: FIPS_KEY, data: FIPS_PT, in_stall: 1, out_stall: 1, exp_ct: FIPS_CT};
    vecs[3] = '{key: B2B_KEY, data: B2B_PT0, in_stall: 0, out_stall: 0, exp_ct: aes_encrypt(B2B_KEY, B2B_PT0)};
    vecs[4] = '{key: B2B_KEY, data: B2B_PT1, in_stall: 0, out_stall: 0, exp_ct: aes_encrypt(B2B_KEY, B2B_PT1)};

    AES_rst_n = 1'b0;
    in_valid  = 1'b0;
    in_word   = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge AES_clk);
    #1 check_reset_state();
    @(negedge AES_clk);
    AES_rst_n = 1'b1;
    @(negedge AES_clk);

    $display("[TB] table vectors");
    for (int v = 0; v < 5; v++) begin
      out_stall = vecs[v].out_stall;
      applyStimulus(vecs[v].key, vecs[v].data, vecs[v].in_stall, 1'b1, vecs[v].exp_ct);
    end
    wait_drain();
    out_stall = 0;

    $display("[TB] timeout with silent core");
    core_mode = 1;
    applyStimulus(FIPS_KEY, FIPS_PT, 1'b0, 1'b0, '0);
    en_cycles  = 0;
    err_pulses = 0;
    repeat (20) begin
      #1;
      if (AES_en) en_cycles++;
      if (timeout_err) err_pulses++;
      @(negedge AES_clk);
    end
    checkOutput("timeout_en_cycles", 128'(en_cycles), 128'(TIMEOUT));
    checkOutput("timeout_err_pulses", 128'(err_pulses), 128'(1));
    #1;
    checkOutput("timeout_in_ready", 128'(in_ready), 128'(1));
    checkOutput("timeout_out_valid", 128'(out_valid), 128'(0));
    @(negedge AES_clk);

    $display("[TB] valid on final timeout cycle");
    core_mode = 2;
    applyStimulus(FIPS_KEY, FIPS_PT, 1'b0, 1'b1, STUB_CT);
    err_pulses = 0;
    repeat (20) begin
      #1;
      if (timeout_err) err_pulses++;
      @(negedge AES_clk);
    end
    checkOutput("tie_no_timeout_err", 128'(err_pulses), 128'(0));
    wait_drain();

    $display("[TB] reset after word 5");
    core_mode = 0;
    for (int i = 0; i < 6; i++) send_word(FIPS_KEY[127-32*(i%4) -: 32] & {32{i < 4}} | FIPS_PT[127-32*(i%4) -: 32] & {32{i >= 4}}, 1'b0);
    pulse_reset();
    applyStimulus(FIPS_KEY, FIPS_PT, 1'b0, 1'b1, FIPS_CT);
    wait_drain();

    $display("[TB] reset mid run");
    core_mode = 1;
    applyStimulus(FIPS_KEY, FIPS_PT, 1'b0, 1'b0, '0);
    @(negedge AES_clk);
    #1 checkOutput("midrun_busy", 128'(busy), 128'(1));
    pulse_reset();
    core_mode = 0;
    applyStimulus(FIPS_KEY, FIPS_PT, 1'b1, 1'b1, FIPS_CT);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_stream_loader.md
# aes_stream_loader

Front-end staging stage directly upstream of the AES core (`AES_top`). It accepts key and plaintext as a stream of 32-bit words over a valid/ready handshake and assembles the 128-bit key and data registers. It then drives `AES_en`, `AES_data_in` and `AES_key_in` into the core and waits for `AES_data_out_valid`. Finally it captures `AES_data_out` and streams the ciphertext back out as four 32-bit words.

## Interface
- `TIMEOUT_CYCLES`, default 64: maximum number of cycles spent in RUN waiting for `AES_data_out_valid`.
- `AES_clk`  in  1  sole clock; all state on rising edge.
- `AES_rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  loader can accept a word.
- `in_word`  in  32  key/data word.
- `out_valid`  out  1  ciphertext word valid.
- `out_ready`  in  1  downstream accepts the word.
- `out_word`  out  32  ciphertext word.
- `busy`  out  1  high in RUN.
- `timeout_err`  out  1  one-cycle pulse when RUN times out.
- `AES_en`  out  1  to core enable.
- `AES_data_in`  out  128  to core plaintext.
- `AES_key_in`  out  128  to core key.
- `AES_data_out`  in  128  from core ciphertext.
- `AES_data_out_valid`  in  1  from core result valid.

## Operation
- States: LOAD, RUN, DRAIN. Reset puts the block in LOAD.
- LOAD:
  - `in_ready`=1. A word is accepted when `in_valid & in_ready`.
  - A 3-bit index counts accepted words, 0..7.
  - Words 0-3 go to the key, MSW first: word 0 is bits [127:96].
  - Words 4-7 go to the data, MSW first.
  - Accepting word 7 moves the state to RUN and wraps the index to 0.
- RUN:
  - `AES_en`=1 and `busy`=1. `AES_data_in` and `AES_key_in` are held stable from registers.
  - A timeout counter increments every cycle.
  - `AES_data_out_valid`=1 has priority: capture `AES_data_out`, go to DRAIN, clear the counter.
  - Otherwise, when the counter reaches `TIMEOUT_CYCLES`-1: pulse `timeout_err`, discard the result, return to LOAD.
- DRAIN:
  - `out_valid`=1. `out_word` is result word [3-idx] (MSW first).
  - Index advances on `out_valid & out_ready`.
  - The 4th accepted word returns the state to LOAD with index 0.
- `AES_data_out_valid` outside RUN is ignored.
- `in_valid` outside LOAD is not accepted, because `in_ready`=0.
- Key and data registers keep their values after a block completes. A new block must still supply all 8 words.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_word`=0, `busy`=0, `timeout_err`=0, `AES_en`=0, `AES_data_in`=0, `AES_key_in`=0. The index, timeout counter and result register are also cleared.
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.
- `AES_en` rises the cycle after word 7 is accepted. It stays high continuously until the cycle after the valid or timeout edge.
- The key and data registers are written only in LOAD. They are guaranteed stable for the whole time `AES_en`=1.
- `out_valid` rises the cycle after `AES_data_out_valid` is sampled. `out_word` is held while `out_ready`=0.
- With `out_ready` tied high, one output word is sent per cycle: four cycles, then LOAD.
- Timeout and valid in the same cycle: valid wins and no error pulse is issued.
- Asynchronous reset mid-RUN or mid-DRAIN drops `AES_en` and `out_valid` immediately and discards partial data.

## Structure
- Shared package `aes_pkg`:
  - state encoding typedef (LOAD/RUN/DRAIN),
  - `AES_BLOCK_W`=128, `AES_WORD_W`=32, `AES_WORDS`=4.
- Sub-module `aes_word_serializer` implements the DRAIN side: a 128-bit register, a 2-bit index and the valid/ready output. It is instantiated once.
- Everything else (LOAD assembly, RUN control, timeout counter) is in the top FSM.

## Test plan
- FIPS-197 vector through the real `AES_top`:
  - key words 00010203, 04050607, 08090a0b, 0c0d0e0f;
  - data words 00112233, 44556677, 8899aabb, ccddeeff;
  - required output words, in order: 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a.
- Random stalls on `in_valid` and on `out_ready` (50% duty): same result.
  - `AES_key_in` and `AES_data_in` never change while `AES_en`=1.
  - `out_word` holds while stalled.
- Stub core that never asserts valid, `TIMEOUT_CYCLES`=8:
  - `AES_en` high for exactly 8 cycles, one `timeout_err` pulse, return to LOAD with `in_ready`=1.
- Stub core pulses valid in the same cycle the counter reaches 7: no `timeout_err`; DRAIN outputs the stub value.
- Reset after word 5 is accepted:
  - all outputs return to their reset values;
  - a following full 8-word load gives the correct FIPS-197 ciphertext.
- Back-to-back blocks with key aa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc:
  - data 000000f0_00000000_00000000_00000000, then a6f2daeb_140fa720_529e75d5_21cbc681;
  - both results match the reference model;
  - `in_ready` is low from RUN through the last DRAIN word.
